dmem_responder: RTL



---
 rtl/common_pkg.sv | 6 +
 rtl/memory_pkg.sv | 42 ++++
 rtl/dmem_ram.sv | 24 ++
 rtl/dmem_responder.sv | 115 +++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Types shared by every block of the core.
package common_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/memory_pkg.sv
// Memory-stage request types plus the data-memory responder's state and limits.
package memory_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
  } mem_read_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [31:0] data;
    logic [3:0]  strobe;
  } mem_write_req;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int DMEM_LAT_MAX = 7;
  localparam int DMEM_CNT_W   = $clog2(DMEM_LAT_MAX + 1);

  // Halfwords need an even address, words need a 4-byte aligned one.
  function automatic logic isMisaligned(input logic [1:0] low, input msize_t size);
    logic bad;
    bad = 1'b0;
    if (size == MSIZE2 && low[0] != 1'b0) bad = 1'b1;
    if (size == MSIZE4 && low != 2'b00)   bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered,
// read-before-write output.
module dmem_ram
  import common_pkg::*;
#(
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic [AWIDTH-1:0] index,
  input  logic [3:0]        we,
  input  word_t             wdata,
  output word_t             rdata
);

  word_t mem [0:(1 << AWIDTH) - 1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a memory-stage request, stalls the pipeline
// for LATENCY cycles and completes it against the local RAM.
module dmem_responder
  import common_pkg::*;
  import memory_pkg::*;
#(
  parameter int AWIDTH  = 10,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  mem_read_req  mread,
  input  mem_write_req mwrite,
  output word_t        rd,
  output logic         stall,
  output logic         done,
  output logic         addr_err
);

  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);

  dmem_state_t           state;
  dmem_state_t           nextState;
  logic [DMEM_CNT_W-1:0] cnt;

  logic        reqValid;
  logic [31:0] selAddr;
  msize_t      selSize;
  logic        selMis;

  logic [31:0] reqAddr;
  word_t       reqData;
  logic [3:0]  reqStrobe;
  logic        reqRead;
  logic        reqWrite;
  logic        reqMis;

  word_t             ramQ;
  word_t             rdHold;
  logic [AWIDTH-1:0] ramIndex;
  logic [3:0]        ramWe;

  // A combined read+write names the same location, so the write side wins.
  assign reqValid = mread.valid | mwrite.valid;
  assign selAddr  = mwrite.valid ? mwrite.addr : mread.addr;
  assign selSize  = mwrite.valid ? mwrite.size : mread.size;
  assign selMis   = isMisaligned(selAddr[1:0], selSize);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (reqValid) nextState = (selMis || LATENCY == 1) ? DONE : BUSY;
      BUSY: if (cnt <= DMEM_CNT_W'(1)) nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      reqAddr   <= '0;
      reqData   <= '0;
      reqStrobe <= '0;
      reqRead   <= 1'b0;
      reqWrite  <= 1'b0;
      reqMis    <= 1'b0;
    end else begin
      if (state == IDLE && reqValid) begin
        reqAddr   <= selAddr;
        reqData   <= mwrite.data;
        reqStrobe <= mwrite.strobe;
        reqRead   <= mread.valid;
        reqWrite  <= mwrite.valid;
        reqMis    <= selMis;
      end
      if (nextState == BUSY && state == IDLE) cnt <= CNT_LOAD;
      else if (state == BUSY)                 cnt <= cnt - DMEM_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdHold <= '0;
    else if (state == DONE && reqRead) rdHold <= reqMis ? '0 : ramQ;
  end

  // The read is issued in the cycle before DONE, which for a one-cycle
  // latency is the acceptance cycle itself, hence the live address in IDLE.
  always_comb begin
    stall    = !reset && ((state == IDLE && reqValid) || state == BUSY);
    done     = (state == DONE);
    addr_err = (state == DONE) && reqMis;
    rd       = rdHold;
    if (state == DONE) begin
      if (reqMis)       rd = '0;
      else if (reqRead) rd = ramQ;
    end
    ramIndex = (state == IDLE) ? selAddr[AWIDTH+1:2] : reqAddr[AWIDTH+1:2];
    ramWe    = (state == DONE && reqWrite && !reqMis) ? reqStrobe : 4'b0000;
  end

  dmem_ram #(.AWIDTH(AWIDTH)) ram (
    .clk  (clk),
    .index(ramIndex),
    .we   (ramWe),
    .wdata(reqData),
    .rdata(ramQ)
  );

endmodule
